// File: rtl/hi_ssp_pkg.sv
// Shared constants for the HF SSP word receiver: word width, FSM state type,
// FIFO depth bounds and the minor_mode / subcarrier codes used by the reader stage.
package hi_ssp_pkg;

   localparam int WORD_W = 16;

   // FIFO_DEPTH must be a power of two within these bounds.
   localparam int FIFO_DEPTH_MIN = 2;
   localparam int FIFO_DEPTH_MAX = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } rx_state_t;

   localparam logic [3:0] MODE_RECEIVE_IQ          = 4'd0;
   localparam logic [3:0] MODE_RECEIVE_AMPLITUDE   = 4'd1;
   localparam logic [3:0] MODE_RECEIVE_PHASE       = 4'd2;
   localparam logic [3:0] MODE_SEND_FULL_MOD       = 4'd3;
   localparam logic [3:0] MODE_SEND_SHALLOW_MOD    = 4'd4;
   localparam logic [3:0] MODE_SNIFF_IQ            = 4'd5;
   localparam logic [3:0] MODE_SNIFF_AMPLITUDE     = 4'd6;
   localparam logic [3:0] MODE_SNIFF_PHASE         = 4'd7;
   localparam logic [3:0] MODE_SEND_JAM            = 4'd8;

   localparam logic [1:0] SUBCARRIER_848_KHZ       = 2'd0;
   localparam logic [1:0] SUBCARRIER_424_KHZ       = 2'd1;
   localparam logic [1:0] SUBCARRIER_212_KHZ       = 2'd2;
   localparam logic [1:0] SUBCARRIER_2SC_424_484   = 2'd3;

endpackage

// File: rtl/hi_ssp_word_fifo.sv
// Word FIFO with a registered head word (word_data) and sticky overflow flag.
// Pointers carry one extra wrap bit so full/empty come from an MSB compare.
module hi_ssp_word_fifo
   import hi_ssp_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [WORD_W-1:0] push_data,
   input  logic              pop_ready,
   output logic              word_valid,
   output logic [WORD_W-1:0] word_data,
   output logic              overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr, wr_next, rd_next;
   logic              empty, full, pop, push_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop     = !empty && pop_ready;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign push_ok = push && (!full || pop);
   assign wr_next = wr_ptr + {{AW{1'b0}}, push_ok};
   assign rd_next = rd_ptr + {{AW{1'b0}}, pop};

   assign word_valid = !empty;

   // NOTE: storage carries no reset; only pointers define which entries are live,
   // so clearing the array would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         word_data <= '0;
         overflow  <= 1'b0;
      end else begin
         wr_ptr <= wr_next;
         rd_ptr <= rd_next;
         if (push && full && !pop) begin
            overflow <= 1'b1;
         end
         // Reload the head register only when the FIFO stays non-empty; the slot
         // being written this cycle is forwarded straight from push_data.
         if (rd_next != wr_next) begin
            if (push_ok && (rd_next == wr_ptr)) begin
               word_data <= push_data;
            end else begin
               word_data <= mem[rd_next[AW-1:0]];
            end
         end
      end
   end

endmodule

// File: rtl/hi_ssp_word_rx.sv
// Deserializes framed 16-bit SSP words into a FIFO and decodes mode fields.
// Optional field decode is built only when HI_SSP_RX_FIELD_DECODE_EN is defined.
module hi_ssp_word_rx
   import hi_ssp_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic              ck_1356meg,
   input  logic              reset,
   input  logic              ssp_clk,
   input  logic              ssp_frame,
   input  logic              ssp_din,
   input  logic [1:0]        subcarrier_frequency,
   input  logic [3:0]        minor_mode,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [WORD_W-1:0] word_data,
   output logic [1:0]        fsk_out,
   output logic [1:0]        reader_bits,
   output logic              overflow,
   output logic              frame_err
);

   logic [1:0]        clk_sync, frame_sync, din_sync;
   logic              clk_prev;
   logic              bit_strobe, bit_val, bit_frame;
   rx_state_t         state, state_next;
   logic [4:0]        bit_cnt;
   logic [WORD_W-1:0] shreg;
   logic              push;

   always_ff @(posedge ck_1356meg) begin
      if (reset) begin
         clk_sync   <= '0;
         frame_sync <= '0;
         din_sync   <= '0;
         clk_prev   <= 1'b0;
      end else begin
         clk_sync   <= {clk_sync[0], ssp_clk};
         frame_sync <= {frame_sync[0], ssp_frame};
         din_sync   <= {din_sync[0], ssp_din};
         clk_prev   <= clk_sync[1];
      end
   end

   // Data is stable mid-bit, so sample on the synchronized falling edge.
   assign bit_strobe = clk_prev && !clk_sync[1];
   assign bit_val    = din_sync[1];
   assign bit_frame  = frame_sync[1];

   always_ff @(posedge ck_1356meg) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: default assignment first so no path through the case leaves
   // state_next unassigned, which would infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (bit_strobe && bit_frame) state_next = ST_SHIFT;
         ST_SHIFT: if (bit_strobe && !bit_frame && (bit_cnt == 5'd15)) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      push = (state == ST_DONE);
   end

   always_ff @(posedge ck_1356meg) begin
      if (reset) begin
         shreg     <= '0;
         bit_cnt   <= '0;
         frame_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bit_strobe && bit_frame) begin
                  shreg   <= {{(WORD_W-1){1'b0}}, bit_val};
                  bit_cnt <= 5'd1;
               end
            end
            ST_SHIFT: begin
               if (bit_strobe) begin
                  if (bit_frame) begin
                     // Early frame: drop the partial word and restart at bit 15.
                     frame_err <= 1'b1;
                     shreg     <= {{(WORD_W-1){1'b0}}, bit_val};
                     bit_cnt   <= 5'd1;
                  end else begin
                     shreg   <= {shreg[WORD_W-2:0], bit_val};
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
            end
            default: bit_cnt <= '0;
         endcase
      end
   end

   hi_ssp_word_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk        (ck_1356meg),
      .reset      (reset),
      .push       (push),
      .push_data  (shreg),
      .pop_ready  (word_ready),
      .word_valid (word_valid),
      .word_data  (word_data),
      .overflow   (overflow)
   );

`ifdef HI_SSP_RX_FIELD_DECODE_EN
   always_comb begin
      fsk_out     = 2'b00;
      reader_bits = 2'b00;
      if (minor_mode == MODE_SNIFF_AMPLITUDE) begin
         reader_bits = word_data[1:0];
         if (subcarrier_frequency == SUBCARRIER_2SC_424_484) begin
            fsk_out = word_data[3:2];
         end
      end else if ((minor_mode == MODE_RECEIVE_AMPLITUDE) &&
                   (subcarrier_frequency == SUBCARRIER_2SC_424_484)) begin
         fsk_out = word_data[15:14];
      end
   end
`else
   logic unused_decode_inputs;
   assign unused_decode_inputs = ^{minor_mode, subcarrier_frequency};
   assign fsk_out     = 2'b00;
   assign reader_bits = 2'b00;
`endif

endmodule

// File: tb/tb_hi_ssp_word_rx.sv
// Directed testbench for hi_ssp_word_rx: framing, decode, overflow, frame error
// and reset behaviour, with hand-computed expected values.
module tb_hi_ssp_word_rx;
   import hi_ssp_pkg::*;

   logic        ck_1356meg = 1'b0;
   logic        reset = 1'b1;
   logic        ssp_clk = 1'b0;
   logic        ssp_frame = 1'b0;
   logic        ssp_din = 1'b0;
   logic [1:0]  subcarrier_frequency = 2'd0;
   logic [3:0]  minor_mode = 4'd0;
   logic        word_ready = 1'b0;
   logic        word_valid;
   logic [15:0] word_data;
   logic [1:0]  fsk_out;
   logic [1:0]  reader_bits;
   logic        overflow;
   logic        frame_err;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [15:0] got_q[$];
   int          valid_rises = 0;
   logic        valid_d = 1'b0;
   logic [1:0]  exp_fsk, exp_rdr;

   hi_ssp_word_rx #(.FIFO_DEPTH(8)) dut (
      .ck_1356meg           (ck_1356meg),
      .reset                (reset),
      .ssp_clk              (ssp_clk),
      .ssp_frame            (ssp_frame),
      .ssp_din              (ssp_din),
      .subcarrier_frequency (subcarrier_frequency),
      .minor_mode           (minor_mode),
      .word_valid           (word_valid),
      .word_ready           (word_ready),
      .word_data            (word_data),
      .fsk_out              (fsk_out),
      .reader_bits          (reader_bits),
      .overflow             (overflow),
      .frame_err            (frame_err)
   );

   always #5 ck_1356meg = ~ck_1356meg;

   // Inputs change 1 ns after posedge, so the negedge sees what the next posedge uses.
   always @(negedge ck_1356meg) begin
      if (word_valid && word_ready) got_q.push_back(word_data);
      if (word_valid && !valid_d) valid_rises++;
      valid_d = word_valid;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge ck_1356meg);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send_bit(input logic f, input logic b);
      step();
      ssp_clk = 1'b1; ssp_frame = f; ssp_din = b;
      step(); step();
      ssp_clk = 1'b0;
      step(); step();
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) send_bit(i == 15, w[i]);
   endtask

   // Last bit is timed so the consumer pops in exactly the cycle the word is pushed:
   // falling edge seen after 2 sync flops, shifted at the 3rd edge, pushed at the 4th.
   task automatic send_word_with_pop(input logic [15:0] w);
      for (int i = 15; i >= 1; i--) send_bit(i == 15, w[i]);
      step();
      ssp_clk = 1'b1; ssp_frame = 1'b0; ssp_din = w[0];
      step(); step();
      ssp_clk = 1'b0;
      step(); step(); step();
      word_ready = 1'b1;
      step();
      word_ready = 1'b0;
      step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      step();
   endtask

   initial begin
      // Reset state
      idle(3);
      check("rst_valid", word_valid, 0);
      check("rst_data", word_data, 0);
      check("rst_fsk", fsk_out, 0);
      check("rst_reader", reader_bits, 0);
      check("rst_overflow", overflow, 0);
      check("rst_frame_err", frame_err, 0);
      reset = 1'b0;
      step();

      // Single word, consumer always ready
      word_ready = 1'b1;
      got_q.delete();
      valid_rises = 0;
      send_word(16'hA55A);
      idle(8);
      check("a55a_count", got_q.size(), 1);
      if (got_q.size() >= 1) check("a55a_data", got_q[0], 16'hA55A);
      check("a55a_pulses", valid_rises, 1);
      check("a55a_frame_err", frame_err, 0);

      // Field decode on the held head word
      word_ready = 1'b0;
      minor_mode = MODE_SNIFF_AMPLITUDE;
      subcarrier_frequency = SUBCARRIER_2SC_424_484;
      send_word(16'h12B6);
      idle(8);
      check("dec_valid", word_valid, 1);
      check("dec_data", word_data, 16'h12B6);
`ifdef HI_SSP_RX_FIELD_DECODE_EN
      exp_fsk = 2'b01; exp_rdr = 2'b10;
`else
      exp_fsk = 2'b00; exp_rdr = 2'b00;
`endif
      check("sniff_2sc_fsk", fsk_out, exp_fsk);
      check("sniff_2sc_reader", reader_bits, exp_rdr);
      subcarrier_frequency = SUBCARRIER_848_KHZ;
      step();
`ifdef HI_SSP_RX_FIELD_DECODE_EN
      exp_fsk = 2'b00; exp_rdr = 2'b10;
`endif
      check("sniff_848_fsk", fsk_out, exp_fsk);
      check("sniff_848_reader", reader_bits, exp_rdr);
      word_ready = 1'b1;
      step();
      word_ready = 1'b0;
      step();

      subcarrier_frequency = SUBCARRIER_2SC_424_484;
      minor_mode = MODE_RECEIVE_AMPLITUDE;
      send_word(16'hC003);
      idle(8);
      check("c003_data", word_data, 16'hC003);
`ifdef HI_SSP_RX_FIELD_DECODE_EN
      exp_fsk = 2'b11; exp_rdr = 2'b00;
`else
      exp_fsk = 2'b00; exp_rdr = 2'b00;
`endif
      check("rxamp_fsk", fsk_out, exp_fsk);
      check("rxamp_reader", reader_bits, exp_rdr);
      minor_mode = MODE_SNIFF_AMPLITUDE;
      step();
`ifdef HI_SSP_RX_FIELD_DECODE_EN
      exp_fsk = 2'b00; exp_rdr = 2'b11;
`endif
      check("sniff_c003_fsk", fsk_out, exp_fsk);
      check("sniff_c003_reader", reader_bits, exp_rdr);
      minor_mode = MODE_RECEIVE_IQ;
      step();
      check("iq_fsk", fsk_out, 0);
      check("iq_reader", reader_bits, 0);
      word_ready = 1'b1;
      step();
      word_ready = 1'b0;
      step();

      // Overflow: nine words into an eight-deep FIFO
      do_reset();
      check("ovf_clear", overflow, 0);
      for (int i = 1; i <= 8; i++) send_word(16'(i));
      idle(8);
      check("ovf_not_yet", overflow, 0);
      send_word(16'h0009);
      idle(8);
      check("ovf_set", overflow, 1);
      check("ovf_head", word_data, 16'h0001);
      got_q.delete();
      word_ready = 1'b1;
      idle(12);
      word_ready = 1'b0;
      step();
      check("ovf_pop_count", got_q.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < got_q.size()) check($sformatf("ovf_pop%0d", i), got_q[i], 16'(i + 1));
      check("ovf_empty", word_valid, 0);
      check("ovf_hold_data", word_data, 16'h0008);

      // Full FIFO, push and pop in the same cycle
      do_reset();
      for (int i = 1; i <= 8; i++) send_word(16'(i));
      idle(8);
      got_q.delete();
      send_word_with_pop(16'h0009);
      idle(8);
      check("simul_overflow", overflow, 0);
      check("simul_popped", got_q.size(), 1);
      check("simul_head", word_data, 16'h0002);
      word_ready = 1'b1;
      idle(12);
      word_ready = 1'b0;
      step();
      check("simul_total", got_q.size(), 9);
      if (got_q.size() == 9) begin
         check("simul_first", got_q[0], 16'h0001);
         check("simul_last", got_q[8], 16'h0009);
      end

      // Frame raised after 7 bits
      do_reset();
      word_ready = 1'b1;
      got_q.delete();
      send_bit(1'b1, 1'b1);
      for (int i = 0; i < 6; i++) send_bit(1'b0, i[0]);
      send_word(16'h00FF);
      idle(8);
      check("ferr_set", frame_err, 1);
      check("ferr_count", got_q.size(), 1);
      if (got_q.size() >= 1) check("ferr_data", got_q[0], 16'h00FF);

      // Reset mid-word
      got_q.delete();
      minor_mode = MODE_SNIFF_AMPLITUDE;
      for (int i = 0; i < 10; i++) send_bit(i == 0, 1'b1);
      reset = 1'b1;
      idle(2);
      check("mid_rst_valid", word_valid, 0);
      check("mid_rst_data", word_data, 0);
      check("mid_rst_fsk", fsk_out, 0);
      check("mid_rst_reader", reader_bits, 0);
      check("mid_rst_frame_err", frame_err, 0);
      reset = 1'b0;
      step();
      check("post_rst_data", word_data, 0);
      send_word(16'h1234);
      idle(8);
      check("post_rst_count", got_q.size(), 1);
      if (got_q.size() >= 1) check("post_rst_word", got_q[0], 16'h1234);
      check("post_rst_frame_err", frame_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
